// File: rtl/inexrecur_pkg.sv
// Shared widths, depth and FSM state type for the inexrecur register-file arbiter.
package inexrecur_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 4096;
   localparam int unsigned CNT_W  = 13;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-port read arbiter. INEXRECUR_ARB_RR_EN selects round-robin; otherwise fixed
// priority with port 0 winning and no pointer state.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

`ifdef INEXRECUR_ARB_RR_EN
   logic ptr_q;

   // After a grant the pointer favours the port that was not served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else if (advance && (|req)) begin
         ptr_q <= gnt[0];
      end
   end

   always_comb begin
      gnt = 2'b00;
      if (ptr_q) begin
         if (req[1])      gnt = 2'b10;
         else if (req[0]) gnt = 2'b01;
      end else begin
         if (req[0])      gnt = 2'b01;
         else if (req[1]) gnt = 2'b10;
      end
   end
`else
   logic unused_rr;

   assign unused_rr = ^{clk, rst_n, advance};
   assign gnt[0]    = req[0];
   assign gnt[1]    = req[1] & ~req[0];
`endif

endmodule

// File: rtl/inexrecur_arbiter.sv
// Serialises one writer and two random-read ports onto a single-port register file.
// Read arbitration policy is chosen by INEXRECUR_ARB_RR_EN (see rr_arb2).
module inexrecur_arbiter
   import inexrecur_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_err,
   input  logic              rd0_req,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic              rd0_ack,
   output logic [DATA_W-1:0] rd0_data,
   output logic              rd0_err,
   input  logic              rd1_req,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic              rd1_ack,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd1_err,
   output logic              rf_we,
   output logic [DATA_W-1:0] rf_w_data,
   output logic              rf_ran_re,
   output logic [ADDR_W-1:0] rf_ran_r_addr,
   input  logic [DATA_W-1:0] rf_ran_r_data,
   output logic [CNT_W-1:0]  count,
   output logic              full
);

   state_e     state_q;
   logic       rd_port_q;
   logic [1:0] gnt;
   logic       advance;
   logic       rd_hit;

   assign advance = (state_q == StIdle) && !wr_req;
   assign rd_hit  = CNT_W'(rf_ran_r_addr) < count;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     ({rd1_req, rd0_req}),
      .advance (advance),
      .gnt     (gnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         rd_port_q     <= 1'b0;
         wr_ack        <= 1'b0;
         wr_err        <= 1'b0;
         rd0_ack       <= 1'b0;
         rd0_err       <= 1'b0;
         rd0_data      <= '0;
         rd1_ack       <= 1'b0;
         rd1_err       <= 1'b0;
         rd1_data      <= '0;
         rf_we         <= 1'b0;
         rf_w_data     <= '0;
         rf_ran_re     <= 1'b0;
         rf_ran_r_addr <= '0;
         count         <= '0;
         full          <= 1'b0;
      end else begin
         // Strobes are single-cycle; only IDLE raises the register-file controls.
         wr_ack        <= 1'b0;
         wr_err        <= 1'b0;
         rd0_ack       <= 1'b0;
         rd0_err       <= 1'b0;
         rd1_ack       <= 1'b0;
         rd1_err       <= 1'b0;
         rf_we         <= 1'b0;
         rf_w_data     <= '0;
         rf_ran_re     <= 1'b0;
         rf_ran_r_addr <= '0;
         unique case (state_q)
            StIdle: begin
               if (wr_req) begin
                  state_q   <= StWrite;
                  rf_we     <= !full;
                  rf_w_data <= full ? '0 : wr_data;
               end else if (|gnt) begin
                  state_q       <= StRead;
                  rd_port_q     <= gnt[1];
                  rf_ran_re     <= 1'b1;
                  rf_ran_r_addr <= gnt[1] ? rd1_addr : rd0_addr;
               end
            end
            StWrite: begin
               if (!full) begin
                  count <= count + CNT_W'(1);
                  full  <= (count == CNT_W'(DEPTH - 1));
               end
               wr_ack  <= 1'b1;
               wr_err  <= full;
               state_q <= StResp;
            end
            StRead: begin
               if (rd_port_q) begin
                  rd1_data <= rd_hit ? rf_ran_r_data : '0;
                  rd1_ack  <= 1'b1;
                  rd1_err  <= !rd_hit;
               end else begin
                  rd0_data <= rd_hit ? rf_ran_r_data : '0;
                  rd0_ack  <= 1'b1;
                  rd0_err  <= !rd_hit;
               end
               state_q <= StResp;
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inexrecur_arbiter.sv
// Self-checking bench for inexrecur_arbiter against a queue-based model of the written words.
module tb_inexrecur_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_req;
   logic [31:0] wr_data;
   logic        wr_ack, wr_err;
   logic        rd0_req, rd1_req;
   logic [11:0] rd0_addr, rd1_addr;
   logic        rd0_ack, rd1_ack, rd0_err, rd1_err;
   logic [31:0] rd0_data, rd1_data;
   logic        rf_we, rf_ran_re;
   logic [31:0] rf_w_data, rf_ran_r_data;
   logic [11:0] rf_ran_r_addr;
   logic [12:0] count;
   logic        full;

   int          n_assert = 0;
   int          n_fail   = 0;

   // Reference model: words in write order, last data seen per port, round-robin preference.
   logic [31:0] model_q[$];
   logic [31:0] exp_rd_data[2];
   int          rr_pref;

   // Register-file stand-in: appends on each write, combinational random read.
   logic [31:0] rf_mem[4096];
   int          rf_widx;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) rf_widx <= 0;
      else if (rf_we) begin
         rf_mem[rf_widx % 4096] <= rf_w_data;
         rf_widx <= rf_widx + 1;
      end
   end
   assign rf_ran_r_data = rf_mem[rf_ran_r_addr];

   inexrecur_arbiter dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_req        (wr_req),
      .wr_data       (wr_data),
      .wr_ack        (wr_ack),
      .wr_err        (wr_err),
      .rd0_req       (rd0_req),
      .rd0_addr      (rd0_addr),
      .rd0_ack       (rd0_ack),
      .rd0_data      (rd0_data),
      .rd0_err       (rd0_err),
      .rd1_req       (rd1_req),
      .rd1_addr      (rd1_addr),
      .rd1_ack       (rd1_ack),
      .rd1_data      (rd1_data),
      .rd1_err       (rd1_err),
      .rf_we         (rf_we),
      .rf_w_data     (rf_w_data),
      .rf_ran_re     (rf_ran_re),
      .rf_ran_r_addr (rf_ran_r_addr),
      .rf_ran_r_data (rf_ran_r_data),
      .count         (count),
      .full          (full)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rd_ack_of(input int p);
      return (p != 0) ? rd1_ack : rd0_ack;
   endfunction
   function automatic logic rd_err_of(input int p);
      return (p != 0) ? rd1_err : rd0_err;
   endfunction
   function automatic logic [31:0] rd_data_of(input int p);
      return (p != 0) ? rd1_data : rd0_data;
   endfunction

   task automatic set_rd(input int p, input logic v, input logic [11:0] a);
      if (p != 0) begin rd1_req = v; rd1_addr = a; end
      else        begin rd0_req = v; rd0_addr = a; end
   endtask

   function automatic logic [31:0] model_read(input int a);
      return (a < model_q.size()) ? model_q[a] : 32'h0;
   endfunction

   // Which port the arbiter should serve given the ports currently pending.
   function automatic int pick(input bit p0, input bit p1);
`ifdef INEXRECUR_ARB_RR_EN
      if (rr_pref == 1) return p1 ? 1 : 0;
      return p0 ? 0 : 1;
`else
      return p0 ? 0 : 1;
`endif
   endfunction

   task automatic note_grant(input int p);
      rr_pref = 1 - p;
   endtask

   // Starts at a negedge in IDLE, ends at a negedge in IDLE.
   task automatic do_write(input logic [31:0] d);
      bit was_full;
      was_full = (model_q.size() == 4096);
      wr_req = 1'b1;
      wr_data = d;
      @(negedge clk);
      chk("wr_rf_we", rf_we, !was_full);
      if (!was_full) chk("wr_rf_w_data", rf_w_data, d);
      chk("wr_early_ack", wr_ack, 0);
      chk("wr_no_read", rf_ran_re, 0);
      @(negedge clk);
      chk("wr_ack", wr_ack, 1);
      chk("wr_err", wr_err, was_full);
      chk("wr_rf_we_off", rf_we, 0);
      if (!was_full) model_q.push_back(d);
      chk("count", count, model_q.size());
      chk("full", full, model_q.size() == 4096);
      wr_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_read(input int p, input int a);
      logic [31:0] exp_d;
      exp_d = model_read(a);
      set_rd(p, 1'b1, 12'(a));
      @(negedge clk);
      chk("rd_rf_re", rf_ran_re, 1);
      chk("rd_rf_addr", rf_ran_r_addr, a);
      chk("rd_no_write", rf_we, 0);
      chk("rd_early_ack", rd_ack_of(p), 0);
      @(negedge clk);
      chk("rd_ack", rd_ack_of(p), 1);
      chk("rd_other_ack", rd_ack_of(1 - p), 0);
      chk("rd_err", rd_err_of(p), a >= model_q.size());
      chk("rd_data", rd_data_of(p), exp_d);
      chk("rd_other_held", rd_data_of(1 - p), exp_rd_data[1 - p]);
      chk("rd_rf_re_off", rf_ran_re, 0);
      exp_rd_data[p] = exp_d;
      note_grant(p);
      set_rd(p, 1'b0, 12'(a));
      @(negedge clk);
   endtask

   // Both read ports (addr 0 / addr 1) plus optionally the writer request together.
   task automatic contend(input bit with_wr, input bit reassert, input int n_reads);
      bit pend[2];
      bit re_next[2];
      bit wr_pend;
      int got;
      int exp_p;
      int obs_p;
      pend = '{1'b1, 1'b1};
      re_next = '{1'b0, 1'b0};
      wr_pend = with_wr;
      got = 0;
      wr_req = with_wr;
      wr_data = $urandom;
      set_rd(0, 1'b1, 12'd0);
      set_rd(1, 1'b1, 12'd1);
      for (int cyc = 0; cyc < 60 && got < n_reads; cyc++) begin
         @(negedge clk);
         chk("no_rw_overlap", {31'b0, rf_we & rf_ran_re}, 0);
         for (int p = 0; p < 2; p++) begin
            if (re_next[p]) begin
               set_rd(p, 1'b1, 12'(p));
               re_next[p] = 1'b0;
            end
         end
         if (wr_ack) begin
            chk("wr_served_once", wr_pend, 1);
            chk("wr_before_reads", got, 0);
            model_q.push_back(wr_data);
            wr_req = 1'b0;
            wr_pend = 1'b0;
         end
         if (rd0_ack | rd1_ack) begin
            chk("single_rd_ack", {31'b0, rd0_ack & rd1_ack}, 0);
            chk("wr_first", wr_pend, 0);
            obs_p = rd1_ack ? 1 : 0;
            exp_p = pick(pend[0], pend[1]);
            chk("grant_order", obs_p, exp_p);
            chk("contend_data", rd_data_of(exp_p), model_read(exp_p));
            exp_rd_data[exp_p] = model_read(exp_p);
            note_grant(exp_p);
            got++;
            set_rd(obs_p, 1'b0, 12'(obs_p));
            pend[exp_p] = reassert;
            if (reassert && got < n_reads) re_next[obs_p] = 1'b1;
         end
      end
      chk("contend_done", got, n_reads);
      wr_req = 1'b0;
      set_rd(0, 1'b0, 12'd0);
      set_rd(1, 1'b0, 12'd1);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      wr_req = 1'b0;
      wr_data = '0;
      rd0_req = 1'b0;
      rd1_req = 1'b0;
      rd0_addr = '0;
      rd1_addr = '0;
      exp_rd_data = '{32'h0, 32'h0};
      rr_pref = 0;
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_acks", {wr_ack, wr_err, rd0_ack, rd0_err, rd1_ack, rd1_err}, 0);
      chk("rst_rd0_data", rd0_data, 0);
      chk("rst_rd1_data", rd1_data, 0);
      chk("rst_rf", {rf_we, rf_ran_re, rf_ran_r_addr}, 0);
      chk("rst_rf_w_data", rf_w_data, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_write(32'hA5A5_0001);
      do_write(32'h1234_5678);
      do_write(32'hDEAD_BEEF);
      do_read(0, 2);
      do_read(0, 3);
      do_read(1, 0);

      for (int i = 0; i < 30; i++) do_write($urandom);
      for (int i = 0; i < 40; i++) begin
         int p;
         int a;
         p = int'($urandom_range(1, 0));
         a = int'($urandom_range(model_q.size() + 2, 0));
         do_read(p, a);
      end

      contend(1'b1, 1'b0, 2);
      contend(1'b0, 1'b1, 3);
      contend(1'b0, 1'b1, 4);

      // Reset while a read is in flight.
      set_rd(0, 1'b1, 12'd0);
      @(negedge clk);
      chk("mid_rd_in_flight", rf_ran_re, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_ack", {wr_ack, rd0_ack, rd1_ack}, 0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_rd_data", rd0_data | rd1_data, 0);
      chk("mid_rst_rf", {rf_we, rf_ran_re, rf_ran_r_addr}, 0);
      model_q.delete();
      exp_rd_data = '{32'h0, 32'h0};
      rr_pref = 0;
      set_rd(0, 1'b0, 12'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_idle_ack", rd0_ack, 0);

      contend(1'b0, 1'b1, 3);

      for (int i = 0; i < 4096; i++) do_write(32'h5000_0000 + 32'(i));
      do_write(32'hFFFF_FFFF);
      do_read(1, 4095);
      do_read(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/inexrecur_arbiter.md
INEXRECUR_ARBITER -- requirements
Module: inexrecur_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 wr_req  input  1  write request; held high until wr_ack.
REQ-004 wr_data  input  32  write data; stable while wr_req high.
REQ-005 wr_ack  output  1  one-cycle write completion pulse.
REQ-006 wr_err  output  1  valid with wr_ack; 1 = rejected because full.
REQ-007 rd0_req / rd1_req  input  1 each  random-read requests; held high until matching ack.
REQ-008 rd0_addr / rd1_addr  input  12 each  read addresses; stable while req high.
REQ-009 rd0_ack / rd1_ack  output  1 each  one-cycle read completion pulses.
REQ-010 rd0_data / rd1_data  output  32 each  registered read data; valid with ack, held until next grant to same port.
REQ-011 rd0_err / rd1_err  output  1 each  valid with ack; 1 = address >= count.
REQ-012 rf_we  output  1  register-file write enable.
REQ-013 rf_w_data  output  32  register-file write data.
REQ-014 rf_ran_re  output  1  register-file random-read enable.
REQ-015 rf_ran_r_addr  output  12  register-file random-read address.
REQ-016 rf_ran_r_data  input  32  register-file combinational random-read data.
REQ-017 count  output  13  number of entries written, 0..4096.
REQ-018 full  output  1  count == 4096.

Function
REQ-019 FSM states IDLE, WRITE, READ, RESP; exactly one register-file operation in flight, never read and write in the same cycle.
REQ-020 IDLE: wr_req high -> WRITE; else any rd req -> READ with granted port latched; else stay.
REQ-021 Write has priority over both reads.
REQ-022 WRITE (one cycle): rf_we=1, rf_w_data=wr_data if count<4096 and count increments by 1; if full, rf_we=0, count unchanged, error latched; -> RESP.
REQ-023 READ (one cycle): rf_ran_re=1, rf_ran_r_addr=granted address; at clock edge granted rdN_data <= rf_ran_r_data if addr<count, else 0 with error latched; -> RESP.
REQ-024 RESP (one cycle): pulse ack (and err) for the granted requester only; -> IDLE.
REQ-025 Latency: req sampled high in IDLE at cycle N -> ack high in cycle N+2.
REQ-026 Requester drops req on the edge where it samples ack; re-asserting in the following IDLE cycle starts a new transaction.
REQ-027 rf_we, rf_ran_re, rf_ran_r_addr are 0 in every state other than WRITE/READ respectively.
REQ-028 count saturates at 4096; never wraps.

Reset
REQ-029 rst_n low: state IDLE, count 0, full 0, all acks/errs 0, rdN_data 0, rf_* outputs 0, round-robin pointer to port 0.
REQ-030 Reset mid-transaction aborts it with no ack; requesters re-issue after reset.

Configuration
REQ-031 INEXRECUR_ARB_RR_EN defined: reads arbitrated round-robin; pointer moves to the other port after each read grant.
REQ-032 INEXRECUR_ARB_RR_EN undefined: fixed priority, rd0 over rd1; no pointer state.

Structure
REQ-033 Package inexrecur_pkg holds ADDR_W=12, DATA_W=32, DEPTH=4096 and the FSM state enum.
REQ-034 Sub-module rr_arb2: 2-request arbiter with grant-advance input, honouring INEXRECUR_ARB_RR_EN.

Verification
REQ-035 Write 0xA5A5_0001 from reset -> rf_we high in cycle N+1, wr_ack cycle N+2, wr_err 0, count 1.
REQ-036 After 3 writes, rd0 addr 2 -> rd0_data = third word, rd0_err 0; rd0 addr 3 -> rd0_data 0, rd0_err 1.
REQ-037 wr_req, rd0_req, rd1_req all high in same IDLE cycle -> write served first, then reads; never rf_we and rf_ran_re together.
REQ-038 rd0 and rd1 held high continuously: with macro, grants alternate rd0, rd1, rd0; without, rd0 always granted first.
REQ-039 4096 writes then one more -> count 4096, full 1, last wr_err 1, no rf_we pulse.
REQ-040 rst_n low during READ -> no ack, count 0, all outputs 0 next cycle.
